// File: rtl/rv32i_monitor_pkg.sv
// Shared types for the rv32i run monitor: FSM states, trace entry layout and
// the trace pointer width helper.
package rv32i_monitor_pkg;

  localparam int unsigned MON_XLEN = 32;
  localparam int unsigned MON_RD_W = 5;

  typedef enum logic [1:0] {
    MON_IDLE = 2'd0,
    MON_RUN  = 2'd1,
    MON_DONE = 2'd2
  } mon_state_e;

  typedef struct packed {
    logic [MON_XLEN-1:0] pc;
    logic [MON_RD_W-1:0] rd;
    logic [MON_XLEN-1:0] data;
  } trace_entry_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rv32i_trace_buffer.sv
// Circular trace buffer: overwrites the oldest entry when full, presents the
// oldest entry on registered show-ahead outputs.
module rv32i_trace_buffer
  import rv32i_monitor_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    push,
  input  logic [XLEN-1:0]         push_pc,
  input  logic [4:0]              push_rd,
  input  logic [XLEN-1:0]         push_data,
  input  logic                    pop,
  output logic                    valid,
  output logic [XLEN-1:0]         head_pc,
  output logic [4:0]              head_rd,
  output logic [XLEN-1:0]         head_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = 2 * XLEN + 5;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          valid_q, valid_d;
  logic [EW-1:0] head_q, head_d;
  logic [EW-1:0] entry_c;
  logic          do_pop_c, full_c, write_c;

  assign entry_c  = {push_pc, push_rd, push_data};
  assign do_pop_c = pop && (count_q != '0);
  assign full_c   = (count_q == CW'(DEPTH));
  assign write_c  = push && !clr;

  // Pointer/occupancy update; a push into a full buffer drags the read pointer along.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      if (full_c) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        if (!do_pop_c) overflow_d = 1'b1;
      end else if (do_pop_c) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        count_d = count_q + CW'(1);
      end
    end else if (do_pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      count_d  = count_q - CW'(1);
    end
  end

  // Next head: the entry being written this cycle bypasses the array.
  always_comb begin
    head_d  = '0;
    valid_d = (count_d != '0);
    if (valid_d) head_d = (write_c && (wr_ptr_q == rd_ptr_d)) ? entry_c : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (write_c) mem_q[wr_ptr_q] <= entry_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      head_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
    end
  end

  assign valid     = valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign head_pc   = head_q[EW-1 -: XLEN];
  assign head_rd   = head_q[XLEN +: 5];
  assign head_data = head_q[XLEN-1:0];

endmodule

// File: rtl/rv32i_run_monitor.sv
// Run monitor for rv32i_cpu: halt/watchdog FSM, result check and write trace.
// Define RUN_MONITOR_X0_FILTER_EN to drop register writes to x0 from the trace.
module rv32i_run_monitor
  import rv32i_monitor_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TRACE_DEPTH    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned HALT_REPEAT    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [XLEN-1:0]               expected,
  input  logic [XLEN-1:0]               pc,
  input  logic                          reg_write,
  input  logic [4:0]                    rd,
  input  logic [XLEN-1:0]               wb_data,
  input  logic [XLEN-1:0]               result,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          timeout,
  output logic [31:0]                   cycle_count,
  output logic [31:0]                   retire_count,
  input  logic                          trace_rd_en,
  output logic                          trace_valid,
  output logic [XLEN-1:0]               trace_pc,
  output logic [4:0]                    trace_rd,
  output logic [XLEN-1:0]               trace_data,
  output logic [$clog2(TRACE_DEPTH):0]  trace_count,
  output logic                          trace_overflow
);

  localparam int unsigned HCW = $clog2(HALT_REPEAT) + 1;

  mon_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_prev_q, pc_prev_d;
  logic [HCW-1:0]  halt_cnt_q, halt_cnt_d;
  logic [31:0]     cycle_q, cycle_d, retire_q, retire_d;
  logic            busy_q, busy_d, done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;
  logic            write_ok_c, capture_c;

`ifdef RUN_MONITOR_X0_FILTER_EN
  assign write_ok_c = reg_write && (rd != 5'd0);
`else
  assign write_ok_c = reg_write;
`endif

  // Start (re)arms from any state; halt beats the watchdog in the same cycle.
  always_comb begin
    state_d    = state_q;
    pc_prev_d  = pc;
    halt_cnt_d = halt_cnt_q;
    cycle_d    = cycle_q;
    retire_d   = retire_q;
    done_d     = done_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    capture_c  = 1'b0;
    if (start) begin
      state_d    = MON_RUN;
      halt_cnt_d = '0;
      cycle_d    = '0;
      retire_d   = '0;
      done_d     = 1'b0;
      pass_d     = 1'b0;
      timeout_d  = 1'b0;
    end else begin
      case (state_q)
        MON_RUN: begin
          cycle_d    = (cycle_q == '1) ? cycle_q : cycle_q + 32'd1;
          halt_cnt_d = (pc == pc_prev_q) ? halt_cnt_q + HCW'(1) : '0;
          capture_c  = write_ok_c;
          if (capture_c) retire_d = retire_q + 32'd1;
          if (halt_cnt_d >= HCW'(HALT_REPEAT - 1)) begin
            state_d   = MON_DONE;
            done_d    = 1'b1;
            pass_d    = (result == expected);
            timeout_d = 1'b0;
          end else if (cycle_d >= 32'(TIMEOUT_CYCLES - 1)) begin
            state_d   = MON_DONE;
            done_d    = 1'b1;
            pass_d    = 1'b0;
            timeout_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d == MON_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MON_IDLE;
      pc_prev_q  <= '0;
      halt_cnt_q <= '0;
      cycle_q    <= '0;
      retire_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_prev_q  <= pc_prev_d;
      halt_cnt_q <= halt_cnt_d;
      cycle_q    <= cycle_d;
      retire_q   <= retire_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
    end
  end

  rv32i_trace_buffer #(
    .XLEN  (XLEN),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk       (clk),
    .rst       (rst),
    .clr       (start),
    .push      (capture_c),
    .push_pc   (pc),
    .push_rd   (rd),
    .push_data (wb_data),
    .pop       (trace_rd_en),
    .valid     (trace_valid),
    .head_pc   (trace_pc),
    .head_rd   (trace_rd),
    .head_data (trace_data),
    .count     (trace_count),
    .overflow  (trace_overflow)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;

endmodule
